// File: rtl/rv32i_types.sv
// Shared types for the instruction-queue reader.
//
// Contents:
//   qr_state_e  reader state: IDLE, WAIT, TWO, ONE
//   MASK_*      out_mask encodings the reader produces
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // nothing buffered, nothing in flight
        WAIT = 2'd1,  // pair popped, arriving on q_data this cycle
        TWO  = 2'd2,  // both buffer slots valid
        ONE  = 2'd3   // only slot 0 valid
    } qr_state_e;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_ONE  = 2'b01;
    localparam logic [1:0] MASK_TWO  = 2'b11;

endpackage

// File: rtl/queue_reader.sv
// queue_reader: pops entry pairs from a dual-width circular queue and
// presents them to a consumer that may take zero, one or two entries per
// cycle. Slot 0 is always the oldest entry.
//
// Ports:
//   clk       the only clock, rising edge
//   rst_n     asynchronous active-low reset
//   flush     synchronous discard of buffered and in-flight entries
//   q_empty   upstream queue empty flag
//   q_pop     pop request; upstream registers a pair onto q_data at this edge
//   q_data    popped pair {slot1, slot0}, valid the cycle after q_pop
//   out_data  pair presented to the consumer {slot1, slot0}
//   out_mask  per-slot valid: 00, 01 or 11
//   out_take  consumer acceptance: 00 none, 01 slot 0, 11 both (10 = 00)
//
// Configuration:
//   QUEUE_READER_BYPASS_EN  when defined, the arriving pair is presented
//                           straight from q_data in WAIT (latency 1);
//                           otherwise WAIT shows nothing (latency 2).
module queue_reader
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               q_empty,
    output logic               q_pop,
    input  logic [2*WIDTH-1:0] q_data,
    output logic [2*WIDTH-1:0] out_data,
    output logic [1:0]         out_mask,
    input  logic [1:0]         out_take
);

    qr_state_e        state_q, state_d;
    logic [WIDTH-1:0] slot0_q, slot1_q;
    logic [WIDTH-1:0] slot0_d, slot1_d;

    logic [WIDTH-1:0] in0, in1;
    logic             take_both;
    logic             take_one;
    logic             drain;

    assign in0       = q_data[WIDTH-1:0];
    assign in1       = q_data[2*WIDTH-1:WIDTH];
    assign take_both = (out_take == 2'b11);
    assign take_one  = (out_take == 2'b01);

    // Drain: everything presented is being consumed, so the buffer is free
    // for a new pair this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        drain = 1'b0;
        unique case (state_q)
            IDLE: drain = 1'b1;
            TWO:  drain = take_both;
            ONE:  drain = out_take[0];
`ifdef QUEUE_READER_BYPASS_EN
            WAIT: drain = take_both;
`else
            WAIT: drain = 1'b0;
`endif
            default: drain = 1'b0;
        endcase
    end

    // rst_n gates the pop because the reset state (IDLE) is itself a drain.
    assign q_pop = drain & ~q_empty & ~flush & rst_n;

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            state_d = IDLE;
            slot0_d = '0;
            slot1_d = '0;
        end else if (drain) begin
            // The buffer empties; a popped pair shows up via WAIT.
            state_d = q_pop ? WAIT : IDLE;
            slot0_d = '0;
            slot1_d = '0;
        end else begin
            unique case (state_q)
                WAIT: begin
`ifdef QUEUE_READER_BYPASS_EN
                    if (take_one) begin
                        // Slot 0 consumed straight off q_data; keep slot 1.
                        state_d = ONE;
                        slot0_d = in1;
                        slot1_d = '0;
                    end else begin
                        state_d = TWO;
                        slot0_d = in0;
                        slot1_d = in1;
                    end
`else
                    state_d = TWO;
                    slot0_d = in0;
                    slot1_d = in1;
`endif
                end
                TWO: begin
                    if (take_one) begin
                        state_d = ONE;
                        slot0_d = slot1_q;
                        slot1_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the two buffer registers are reset together with the state, so
    // out_data reads zero while rst_n is low without any extra output gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    always_comb begin
        out_mask = MASK_NONE;
        out_data = {slot1_q, slot0_q};
        unique case (state_q)
            TWO: out_mask = MASK_TWO;
            ONE: out_mask = MASK_ONE;
`ifdef QUEUE_READER_BYPASS_EN
            WAIT: begin
                out_mask = MASK_TWO;
                out_data = q_data;
            end
`else
            WAIT: out_mask = MASK_NONE;
`endif
            default: out_mask = MASK_NONE;
        endcase
    end

endmodule

// File: doc/queue_reader.md
QUEUE_READER -- requirements
Module: queue_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bit width of one queue entry.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight entries.
REQ-005 SHALL have port q_empty  input  1  empty flag of the upstream dual-width circular queue.
REQ-006 SHALL have port q_pop  output  1  pop request; queue registers two entries onto q_data at the same edge.
REQ-007 SHALL have port q_data  input  2 x WIDTH  popped pair, slot 0 oldest, valid the cycle after q_pop.
REQ-008 SHALL have port out_data  output  2 x WIDTH  pair presented to the consumer, slot 0 oldest.
REQ-009 SHALL have port out_mask  output  2  per-slot valid; only 00, 01, 11 are produced.
REQ-010 SHALL have port out_take  input  2  consumer acceptance; 00 none, 01 slot 0 only, 11 both; 10 illegal.

Function
REQ-011 SHALL implement states IDLE, WAIT, TWO, ONE (out_mask 00, 00, 11, 01 respectively).
REQ-012 SHALL define "drain": IDLE; or TWO with out_take=11; or ONE with out_take[0]=1.
REQ-013 SHALL assert q_pop combinationally exactly when drain, !q_empty and !flush; never in WAIT.
REQ-014 SHALL, on q_pop, transition to WAIT; from WAIT, capture q_data into the buffer and enter TWO.
REQ-015 SHALL, on drain without q_pop, enter IDLE and drive out_data to zero.
REQ-016 SHALL, in TWO with out_take=01, shift slot 1 into slot 0, zero slot 1, enter ONE.
REQ-017 SHALL hold state and out_data unchanged when out_take=00 or out_mask has no valid slot.
REQ-018 SHALL ignore out_take bits for slots whose out_mask bit is 0; 10 treated as 00.
REQ-019 SHALL give pop-to-present latency of 2 cycles: q_pop at cycle N, out_mask=11 at cycle N+2.
REQ-020 SHALL sustain one pair per 2 cycles under continuous out_take=11 and non-empty queue.
REQ-021 SHALL, on flush in any state, enter IDLE, zero out_data and out_mask; a pair arriving in WAIT is discarded.
REQ-022 SHALL give flush priority over out_take and q_pop in the same cycle.
REQ-023 SHALL never pop when q_empty=1, including the cycle a drain occurs.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, out_data=0, out_mask=00, q_pop=0, independent of clk.
REQ-025 SHALL, on deassertion mid-operation, discard any in-flight pair and resume from IDLE on the next edge.

Configuration
REQ-026 SHALL support macro QUEUE_READER_BYPASS_EN.
REQ-027 SHALL, with QUEUE_READER_BYPASS_EN defined, present q_data with out_mask=11 during WAIT, honour out_take there (11 -> drain rules, 01 -> ONE), giving latency 1.
REQ-028 SHALL, without the macro, keep out_mask=00 in WAIT and latency 2 per REQ-019.

Structure
REQ-029 SHALL place the state enum (IDLE, WAIT, TWO, ONE) as a typedef in rv32i_types.
REQ-030 SHALL be a single module with no sub-modules; buffer is two WIDTH-wide registers.

Verification
REQ-031 Reset: rst_n=0 mid-WAIT with q_data=A,B -> out_mask=00, q_pop=0 immediately; A,B never presented.
REQ-032 Basic: q_empty=0, pair 0x11,0x22, out_take=11 at first valid -> q_pop cycle 0, out 0x11/0x22 mask 11 cycle 2, q_pop cycle 2.
REQ-033 Partial: pair 0x33,0x44, take 01 then 01 -> mask 11 -> 01 with out_data[0]=0x44 -> pop on second take.
REQ-034 Empty: q_empty=1 after one pair, take 11 -> IDLE, mask 00, q_pop stays 0 until q_empty=0.
REQ-035 Flush: flush in WAIT and again in TWO with take=11 -> IDLE, no q_pop that cycle, pair discarded.
REQ-036 Bypass (macro defined): pop at cycle 0 -> mask 11 at cycle 1; take 11 with q_empty=0 -> q_pop at cycle 1.
